// File: rtl/core_pipe_dispatch_pkg.sv
// Shared core types and constants for the decode->execute dispatch stage.
// Opcode widths, NOP encodings and the s2 bundle layout live here.
package core_pipe_dispatch_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned XL         = XLEN - 1;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned REG_ADDR_R = REG_W - 1;

  localparam int unsigned ALU_OP_W = 6;
  localparam int unsigned LSU_OP_W = 4;
  localparam int unsigned MDU_OP_W = 4;
  localparam int unsigned CSR_OP_W = 3;
  localparam int unsigned CFU_OP_W = 3;
  localparam int unsigned ALU_OP_R = ALU_OP_W - 1;
  localparam int unsigned LSU_OP_R = LSU_OP_W - 1;
  localparam int unsigned MDU_OP_R = MDU_OP_W - 1;
  localparam int unsigned CSR_OP_R = CSR_OP_W - 1;
  localparam int unsigned CFU_OP_R = CFU_OP_W - 1;

  localparam logic [ALU_OP_R:0] ALU_OP_NOP = '0;
  localparam logic [LSU_OP_R:0] LSU_OP_NOP = '0;
  localparam logic [MDU_OP_R:0] MDU_OP_NOP = '0;
  localparam logic [CSR_OP_R:0] CSR_OP_NOP = '0;
  localparam logic [CFU_OP_R:0] CFU_OP_NOP = '0;

  typedef struct packed {
    logic [XL:0]         pc;
    logic [XL:0]         npc;
    logic [XL:0]         opr_a;
    logic [XL:0]         opr_b;
    logic [XL:0]         opr_c;
    logic [REG_ADDR_R:0] rd;
    logic                rd_wen;
    logic [ALU_OP_R:0]   alu_op;
    logic [LSU_OP_R:0]   lsu_op;
    logic [MDU_OP_R:0]   mdu_op;
    logic [CSR_OP_R:0]   csr_op;
    logic [CFU_OP_R:0]   cfu_op;
    logic                op_w;
    logic [31:0]         instr;
  } s2_bundle_t;

  function automatic s2_bundle_t s2_bundle_rst();
    s2_bundle_t bd;
    bd        = '0;
    bd.alu_op = ALU_OP_NOP;
    bd.lsu_op = LSU_OP_NOP;
    bd.mdu_op = MDU_OP_NOP;
    bd.csr_op = CSR_OP_NOP;
    bd.cfu_op = CFU_OP_NOP;
    return bd;
  endfunction

  // x0 is hardwired to zero, so it can never carry a dependency.
  function automatic logic reg_hit(input logic [REG_ADDR_R:0] rd, input logic [REG_ADDR_R:0] rs);
    return (rd == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/core_pipe_dispatch_if.sv
// Decode/execute dispatch bus. master = decode + execute side, slave = dispatch register.
interface core_pipe_dispatch_if;
  import core_pipe_dispatch_pkg::*;

  logic                s1_valid;
  logic                s1_ready;
  s2_bundle_t          s1_bundle;
  logic [REG_ADDR_R:0] s1_rs1_a;
  logic [REG_ADDR_R:0] s1_rs2_a;
  logic                s1_a_rs1;
  logic                s1_b_rs2;
  logic                s1_c_rs2;

  logic                s2_valid;
  logic                s2_ready;
  s2_bundle_t          s2_bundle;
  logic                s2_rd_wen;
  logic [REG_ADDR_R:0] s2_rd_addr;
  logic [XL:0]         s2_rd_wdata;
  logic                s2_cf_valid;
  logic                s2_cf_ack;

  modport master (
    output s1_valid, s1_bundle, s1_rs1_a, s1_rs2_a, s1_a_rs1, s1_b_rs2, s1_c_rs2,
    output s2_ready, s2_rd_wen, s2_rd_addr, s2_rd_wdata, s2_cf_valid, s2_cf_ack,
    input  s1_ready, s2_valid, s2_bundle
  );

  modport slave (
    input  s1_valid, s1_bundle, s1_rs1_a, s1_rs2_a, s1_a_rs1, s1_b_rs2, s1_c_rs2,
    input  s2_ready, s2_rd_wen, s2_rd_addr, s2_rd_wdata, s2_cf_valid, s2_cf_ack,
    output s1_ready, s2_valid, s2_bundle
  );

endinterface

// File: rtl/core_pipe_dispatch_hazard.sv
// RAW hazard check between decode sources and the instruction in execute.
// Forwarding of the execute write-back is enabled by CORE_DISPATCH_FWD_EN.
module core_pipe_dispatch_hazard
  import core_pipe_dispatch_pkg::*;
(
  input  logic [REG_ADDR_R:0] rs1_a_i,
  input  logic [REG_ADDR_R:0] rs2_a_i,
  input  logic                a_rs1_i,
  input  logic                b_rs2_i,
  input  logic                c_rs2_i,
  input  logic                pend_i,
  input  logic [REG_ADDR_R:0] s2_rd_i,
  input  logic                s2_rd_wen_i,
  input  logic [REG_ADDR_R:0] s2_rd_addr_i,
  input  logic [XL:0]         s2_rd_wdata_i,
  input  logic [XL:0]         opr_a_i,
  input  logic [XL:0]         opr_b_i,
  input  logic [XL:0]         opr_c_i,
  output logic                stall_o,
  output logic [XL:0]         opr_a_o,
  output logic [XL:0]         opr_b_o,
  output logic [XL:0]         opr_c_o
);

  logic hit_a, hit_b, hit_c;

  assign hit_a = pend_i && a_rs1_i && reg_hit(s2_rd_i, rs1_a_i);
  assign hit_b = pend_i && b_rs2_i && reg_hit(s2_rd_i, rs2_a_i);
  assign hit_c = pend_i && c_rs2_i && reg_hit(s2_rd_i, rs2_a_i);

`ifdef CORE_DISPATCH_FWD_EN
  logic wb_rs1, wb_rs2;

  assign wb_rs1 = s2_rd_wen_i && (s2_rd_addr_i == rs1_a_i);
  assign wb_rs2 = s2_rd_wen_i && (s2_rd_addr_i == rs2_a_i);

  // A hit is resolved only if this cycle's write-back targets that same source.
  always_comb begin
    stall_o = (hit_a && !wb_rs1) || ((hit_b || hit_c) && !wb_rs2);
    opr_a_o = (hit_a && wb_rs1) ? s2_rd_wdata_i : opr_a_i;
    opr_b_o = (hit_b && wb_rs2) ? s2_rd_wdata_i : opr_b_i;
    opr_c_o = (hit_c && wb_rs2) ? s2_rd_wdata_i : opr_c_i;
  end
`else
  logic unused_fwd;

  // Without forwarding, wait until the regfile holds the value.
  assign unused_fwd = ^{s2_rd_wen_i, s2_rd_addr_i, s2_rd_wdata_i};

  always_comb begin
    stall_o = hit_a || hit_b || hit_c;
    opr_a_o = opr_a_i;
    opr_b_o = opr_b_i;
    opr_c_o = opr_c_i;
  end
`endif

endmodule

// File: rtl/core_pipe_dispatch.sv
// Decode->execute pipeline register with RAW stall/forward and control-flow kill.
// Optional forwarding: define CORE_DISPATCH_FWD_EN.
module core_pipe_dispatch
  import core_pipe_dispatch_pkg::*;
(
  input  logic                 g_clk,
  input  logic                 g_reset,
  core_pipe_dispatch_if.slave  dif
);

  logic        flush, adv, hz_stall, stall, load;
  logic        s2_valid_q, s2_valid_d;
  logic        pend_q, pend_d;
  s2_bundle_t  s2_bundle_q, s2_bundle_d, s1_fwd;
  logic [XL:0] opr_a_f, opr_b_f, opr_c_f;

  core_pipe_dispatch_hazard u_hazard (
    .rs1_a_i       (dif.s1_rs1_a),
    .rs2_a_i       (dif.s1_rs2_a),
    .a_rs1_i       (dif.s1_a_rs1),
    .b_rs2_i       (dif.s1_b_rs2),
    .c_rs2_i       (dif.s1_c_rs2),
    .pend_i        (pend_q),
    .s2_rd_i       (s2_bundle_q.rd),
    .s2_rd_wen_i   (dif.s2_rd_wen),
    .s2_rd_addr_i  (dif.s2_rd_addr),
    .s2_rd_wdata_i (dif.s2_rd_wdata),
    .opr_a_i       (dif.s1_bundle.opr_a),
    .opr_b_i       (dif.s1_bundle.opr_b),
    .opr_c_i       (dif.s1_bundle.opr_c),
    .stall_o       (hz_stall),
    .opr_a_o       (opr_a_f),
    .opr_b_o       (opr_b_f),
    .opr_c_o       (opr_c_f)
  );

  assign flush        = dif.s2_cf_valid && dif.s2_cf_ack;
  assign adv          = !s2_valid_q || dif.s2_ready;
  assign stall        = dif.s1_valid && hz_stall;
  assign dif.s1_ready = adv && !stall && !flush;
  assign load         = dif.s1_valid && dif.s1_ready;

  always_comb begin
    s1_fwd       = dif.s1_bundle;
    s1_fwd.opr_a = opr_a_f;
    s1_fwd.opr_b = opr_b_f;
    s1_fwd.opr_c = opr_c_f;

    s2_valid_d  = s2_valid_q;
    s2_bundle_d = s2_bundle_q;
    pend_d      = pend_q && !dif.s2_rd_wen;
    if (adv) begin
      // Advancing retires whatever is in s2, so pend tracks only the new entry.
      s2_valid_d = load;
      pend_d     = load && dif.s1_bundle.rd_wen && (dif.s1_bundle.rd != '0);
      if (load) begin
        s2_bundle_d = s1_fwd;
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      s2_valid_q  <= 1'b0;
      pend_q      <= 1'b0;
      s2_bundle_q <= s2_bundle_rst();
    end else begin
      s2_valid_q  <= s2_valid_d;
      pend_q      <= pend_d;
      s2_bundle_q <= s2_bundle_d;
    end
  end

  assign dif.s2_valid  = s2_valid_q;
  assign dif.s2_bundle = s2_bundle_q;

endmodule

// File: tb/tb_core_pipe_dispatch.sv
// Self-checking bench for core_pipe_dispatch: directed scenarios plus a randomized
// run against a transaction-level model of the dispatch register.
module tb_core_pipe_dispatch;
  import core_pipe_dispatch_pkg::*;

`ifdef CORE_DISPATCH_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic g_clk = 1'b0;
  logic g_reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  core_pipe_dispatch_if bus ();

  core_pipe_dispatch u_dut (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .dif     (bus)
  );

  always #5 g_clk = ~g_clk;

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic s2_bundle_t mk(input logic [63:0] pc, input logic [4:0] rd,
                                    input logic wen, input logic [63:0] a,
                                    input logic [63:0] b, input logic [63:0] c);
    s2_bundle_t bd;
    bd        = '0;
    bd.pc     = pc;
    bd.npc    = pc + 64'd4;
    bd.opr_a  = a;
    bd.opr_b  = b;
    bd.opr_c  = c;
    bd.rd     = rd;
    bd.rd_wen = wen;
    bd.alu_op = 6'h1;
    bd.instr  = pc[31:0] ^ 32'h0000_0013;
    return bd;
  endfunction

  task automatic drive_s1(input logic v, input s2_bundle_t bd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic ars1, input logic brs2,
                          input logic crs2);
    bus.s1_valid  = v;
    bus.s1_bundle = bd;
    bus.s1_rs1_a  = rs1;
    bus.s1_rs2_a  = rs2;
    bus.s1_a_rs1  = ars1;
    bus.s1_b_rs2  = brs2;
    bus.s1_c_rs2  = crs2;
  endtask

  task automatic drive_wb(input logic wen, input logic [4:0] addr, input logic [63:0] data);
    bus.s2_rd_wen   = wen;
    bus.s2_rd_addr  = addr;
    bus.s2_rd_wdata = data;
  endtask

  task automatic idle();
    drive_s1(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    drive_wb(1'b0, '0, '0);
    bus.s2_ready    = 1'b1;
    bus.s2_cf_valid = 1'b0;
    bus.s2_cf_ack   = 1'b0;
  endtask

  task automatic drain();
    idle();
    tick();
    tick();
  endtask

  task automatic test_reset();
    idle();
    drive_s1(1'b1, mk(64'h80, 5'd3, 1'b1, 64'h1, 64'h2, 64'h3), 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    tick();
    n_checks++;
    if (bus.s2_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_valid: got %b, expected 1", bus.s2_valid);
    end
    drive_s1(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    bus.s2_ready = 1'b0;
    g_reset      = 1'b1;
    tick();
    g_reset      = 1'b0;
    bus.s2_ready = 1'b1;
    settle();
    n_checks++;
    if (bus.s2_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_s2_valid: got %b, expected 0", bus.s2_valid);
    end
    n_checks++;
    if (bus.s2_bundle.pc !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_s2_pc: got %h, expected 0", bus.s2_bundle.pc);
    end
    n_checks++;
    if (bus.s2_bundle !== '0) begin
      n_fail++;
      $display("FAIL reset_s2_bundle: got %h, expected 0", bus.s2_bundle);
    end
    n_checks++;
    if (bus.s1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_s1_ready: got %b, expected 1", bus.s1_ready);
    end
  endtask

  // addi x5 ; add x6,x5,x5 with execute always ready.
  task automatic test_raw_alu();
    int stalls;
    drain();
    drive_s1(1'b1, mk(64'h100, 5'd5, 1'b1, 64'h10, 64'h7, 64'h0), 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    stalls = 0;
    drive_s1(1'b1, mk(64'h104, 5'd6, 1'b1, 64'hdead, 64'hdead, 64'h0),
             5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
    drive_wb(1'b1, 5'd5, 64'h1234);
    settle();
    for (int i = 0; i < 4 && bus.s1_ready !== 1'b1; i++) begin
      stalls++;
      tick();
      drive_wb(1'b0, '0, '0);
      bus.s1_bundle.opr_a = 64'h1234;
      bus.s1_bundle.opr_b = 64'h1234;
      settle();
    end
    n_checks++;
    if (stalls !== (Fwd ? 0 : 1)) begin
      n_fail++;
      $display("FAIL raw_alu_bubbles: got %0d, expected %0d", stalls, Fwd ? 0 : 1);
    end
    tick();
    idle();
    settle();
    n_checks++;
    if (bus.s2_valid !== 1'b1 || bus.s2_bundle.pc !== 64'h104) begin
      n_fail++;
      $display("FAIL raw_alu_enter: got v=%b pc=%h, expected v=1 pc=104",
               bus.s2_valid, bus.s2_bundle.pc);
    end
    n_checks++;
    if (bus.s2_bundle.opr_a !== 64'h1234 || bus.s2_bundle.opr_b !== 64'h1234) begin
      n_fail++;
      $display("FAIL raw_alu_oprs: got a=%h b=%h, expected 1234", bus.s2_bundle.opr_a,
               bus.s2_bundle.opr_b);
    end
  endtask

  // ld x7 waits 3 cycles for dmem grant; sd with store data from x7 is in s1.
  task automatic test_load_stall();
    drain();
    drive_s1(1'b1, mk(64'h200, 5'd7, 1'b1, 64'h40, 64'h8, 64'h0), 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    bus.s2_ready = 1'b0;
    drive_s1(1'b1, mk(64'h204, 5'd0, 1'b0, 64'h40, 64'h10, 64'hbad),
             5'd2, 5'd7, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++;
      if (bus.s1_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL load_wait_ready[%0d]: got %b, expected 0", i, bus.s1_ready);
      end
      tick();
    end
    bus.s2_ready = 1'b1;
    drive_wb(1'b1, 5'd7, 64'hcafe);
    settle();
`ifdef CORE_DISPATCH_FWD_EN
    n_checks++;
    if (bus.s1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_gnt_ready: got %b, expected 1", bus.s1_ready);
    end
`else
    n_checks++;
    if (bus.s1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_gnt_ready: got %b, expected 0", bus.s1_ready);
    end
    tick();
    drive_wb(1'b0, '0, '0);
    bus.s1_bundle.opr_c = 64'hcafe;
    settle();
    n_checks++;
    if (bus.s1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_after_wb_ready: got %b, expected 1", bus.s1_ready);
    end
`endif
    tick();
    idle();
    settle();
    n_checks++;
    if (bus.s2_valid !== 1'b1 || bus.s2_bundle.pc !== 64'h204 ||
        bus.s2_bundle.opr_c !== 64'hcafe) begin
      n_fail++;
      $display("FAIL load_sd_oprc: got v=%b pc=%h c=%h, expected v=1 pc=204 c=cafe",
               bus.s2_valid, bus.s2_bundle.pc, bus.s2_bundle.opr_c);
    end
  endtask

  task automatic test_flush();
    drain();
    drive_s1(1'b1, mk(64'h100, 5'd0, 1'b0, 64'h1, 64'h2, 64'h0), 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    tick();
    drive_s1(1'b1, mk(64'h104, 5'd9, 1'b1, 64'h3, 64'h4, 64'h0), 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    bus.s2_cf_valid = 1'b1;
    bus.s2_cf_ack   = 1'b1;
    settle();
    n_checks++;
    if (bus.s1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_s1_ready: got %b, expected 0", bus.s1_ready);
    end
    tick();
    idle();
    settle();
    n_checks++;
    if (bus.s2_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_s2_valid: got %b, expected 0", bus.s2_valid);
    end
  endtask

  task automatic test_backpressure();
    s2_bundle_t a_bd, b_bd;
    int seen_a, seen_b;
    drain();
    a_bd = mk(64'h300, 5'd4, 1'b1, 64'haa, 64'hbb, 64'hcc);
    b_bd = mk(64'h304, 5'd8, 1'b1, 64'h11, 64'h22, 64'h33);
    drive_s1(1'b1, a_bd, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    tick();
    seen_a = 1;
    seen_b = 0;
    bus.s2_ready = 1'b0;
    drive_s1(1'b1, b_bd, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      settle();
      n_checks++;
      if (bus.s1_ready !== 1'b0 || bus.s2_valid !== 1'b1 || bus.s2_bundle !== a_bd) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b pc=%h, expected rdy=0 v=1 pc=300",
                 i, bus.s1_ready, bus.s2_valid, bus.s2_bundle.pc);
      end
      tick();
    end
    bus.s2_ready = 1'b1;
    settle();
    n_checks++;
    if (bus.s1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b, expected 1", bus.s1_ready);
    end
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      settle();
      if (bus.s2_valid === 1'b1 && bus.s2_bundle === a_bd) seen_a++;
      if (bus.s2_valid === 1'b1 && bus.s2_bundle === b_bd) seen_b++;
      tick();
    end
    n_checks++;
    if (seen_a !== 1 || seen_b !== 1) begin
      n_fail++;
      $display("FAIL bp_once: got a=%0d b=%0d, expected a=1 b=1", seen_a, seen_b);
    end
  endtask

  task automatic test_x0();
    drain();
    drive_s1(1'b1, mk(64'h400, 5'd0, 1'b1, 64'h1, 64'h2, 64'h0), 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    tick();
    drive_s1(1'b1, mk(64'h404, 5'd3, 1'b1, 64'h55, 64'h66, 64'h0), 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    drive_wb(1'b1, 5'd0, 64'h99);
    settle();
    n_checks++;
    if (bus.s1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL x0_ready: got %b, expected 1", bus.s1_ready);
    end
    tick();
    idle();
    settle();
    n_checks++;
    if (bus.s2_bundle.opr_a !== 64'h55 || bus.s2_bundle.opr_b !== 64'h66) begin
      n_fail++;
      $display("FAIL x0_oprs: got a=%h b=%h, expected a=55 b=66", bus.s2_bundle.opr_a,
               bus.s2_bundle.opr_b);
    end
  endtask

  // Model: m_valid/m_bd is the instruction held in execute, m_pend means it still
  // owes a GPR write that decode readers must wait for (or take from write-back).
  task automatic test_random();
    logic       m_valid, m_pend, v, rdy, wen, cf, ack, ars1, brs2, crs2, adv, flush;
    logic       ha, hb, hc, fa, fb, fc, blocked, exp_rdy;
    logic [4:0] rs1, rs2, addr;
    logic [63:0] data;
    s2_bundle_t m_bd, in_bd;
    idle();
    g_reset = 1'b1;
    tick();
    g_reset = 1'b0;
    m_valid = 1'b0;
    m_pend  = 1'b0;
    m_bd    = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_bd = mk({$urandom, $urandom}, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      v     = ($urandom_range(0, 3) != 0);
      rs1   = 5'($urandom_range(0, 3));
      rs2   = 5'($urandom_range(0, 3));
      ars1  = 1'($urandom_range(0, 1));
      brs2  = 1'($urandom_range(0, 1));
      crs2  = 1'($urandom_range(0, 1));
      rdy   = ($urandom_range(0, 2) != 0);
      wen   = ($urandom_range(0, 2) == 0);
      addr  = ($urandom_range(0, 1) == 1) ? m_bd.rd : 5'($urandom_range(0, 3));
      data  = {$urandom, $urandom};
      cf    = ($urandom_range(0, 7) == 0);
      ack   = cf && ($urandom_range(0, 1) == 1);
      drive_s1(v, in_bd, rs1, rs2, ars1, brs2, crs2);
      drive_wb(wen, addr, data);
      bus.s2_ready    = rdy;
      bus.s2_cf_valid = cf;
      bus.s2_cf_ack   = ack;
      settle();

      adv   = !m_valid || rdy;
      flush = cf && ack;
      ha    = m_pend && ars1 && rs1 != 0 && rs1 == m_bd.rd;
      hb    = m_pend && brs2 && rs2 != 0 && rs2 == m_bd.rd;
      hc    = m_pend && crs2 && rs2 != 0 && rs2 == m_bd.rd;
      fa    = Fwd && ha && wen && addr == rs1;
      fb    = Fwd && hb && wen && addr == rs2;
      fc    = Fwd && hc && wen && addr == rs2;
      blocked = (ha && !fa) || (hb && !fb) || (hc && !fc);
      exp_rdy = adv && !(v && blocked) && !flush;
      n_checks++;
      if (bus.s1_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rand_s1_ready[%0d]: got %b, expected %b", cyc, bus.s1_ready, exp_rdy);
      end

      if (adv) begin
        if (v && exp_rdy) begin
          m_bd = in_bd;
          if (fa) m_bd.opr_a = data;
          if (fb) m_bd.opr_b = data;
          if (fc) m_bd.opr_c = data;
          m_valid = 1'b1;
          m_pend  = in_bd.rd_wen && in_bd.rd != 0;
        end else begin
          m_valid = 1'b0;
          m_pend  = 1'b0;
        end
      end else if (wen) begin
        m_pend = 1'b0;
      end
      tick();

      n_checks++;
      if (bus.s2_valid !== m_valid) begin
        n_fail++;
        $display("FAIL rand_s2_valid[%0d]: got %b, expected %b", cyc, bus.s2_valid, m_valid);
      end
      if (m_valid) begin
        n_checks++;
        if (bus.s2_bundle !== m_bd) begin
          n_fail++;
          $display("FAIL rand_s2_bundle[%0d]: got pc=%h a=%h b=%h c=%h, expected pc=%h a=%h b=%h c=%h",
                   cyc, bus.s2_bundle.pc, bus.s2_bundle.opr_a, bus.s2_bundle.opr_b,
                   bus.s2_bundle.opr_c, m_bd.pc, m_bd.opr_a, m_bd.opr_b, m_bd.opr_c);
        end
      end
    end
    idle();
  endtask

  initial begin
    g_reset = 1'b1;
    idle();
    tick();
    tick();
    g_reset = 1'b0;
    test_reset();
    test_raw_alu();
    test_load_stall();
    test_flush();
    test_backpressure();
    test_x0();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
